// File: rtl/pdm_mic_decimator.sv
// PDM mic front end: mic clock gen, edge capture (ch0 rise, ch1 fall), box-car decimation to signed samples.
// Sample lands 1 clk after the frame's last captured bit; held until valid&&ready, overwrite sets sticky overrun.
module pdm_mic_decimator #(
    parameter int CLK_DIV  = 32,
    parameter int DECIM    = 256,
    parameter int OUT_W    = 8,
    parameter int CHANNELS = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      en_in,
    input  logic                      mic_data_in,
    output logic                      mic_clk_out,
    output logic                      pdm_tick_out,
    output logic [CHANNELS*OUT_W-1:0] sample_out,
    output logic                      sample_valid_out,
    input  logic                      sample_ready_in,
    output logic                      overrun_out
);
    localparam int L    = $clog2(DECIM);
    localparam int CW   = $clog2(CLK_DIV);
    localparam int SHR  = (L >= OUT_W) ? L - OUT_W : 0;
    localparam int SHL  = (L <  OUT_W) ? OUT_W - L : 0;
    localparam int MAXV = (1 << (OUT_W - 1)) - 1;
    localparam int MINV = -(1 << (OUT_W - 1));

    logic [CW-1:0]               cnt;
    logic                        prev_clk;
    logic [L-1:0]                bit_cnt;
    logic [CHANNELS-1:0][L:0]    tally;
    logic [CHANNELS-1:0][L:0]    tally_nxt;
    logic [CHANNELS-1:0]         cap;
    logic [CHANNELS*OUT_W-1:0]   conv;
    logic                        rise;
    logic                        fall;
    logic                        frame_done;

    // Centre the ones count around zero, scale to OUT_W bits, saturate (full-ones lands one above max).
    function automatic logic [OUT_W-1:0] to_sample(input logic [L:0] t);
        int c;
        int v;
        c = int'(t) - DECIM / 2;
        v = (c >>> SHR) <<< SHL;
        if (v > MAXV)
            v = MAXV;
        else if (v < MINV)
            v = MINV;
        return v[OUT_W-1:0];
    endfunction

    assign rise         = mic_clk_out && !prev_clk;
    assign fall         = !mic_clk_out && prev_clk;
    assign pdm_tick_out = rise;

    always_comb begin
        cap       = '0;
        tally_nxt = '0;
        conv      = '0;
        cap[0]    = en_in && rise;
        if (CHANNELS > 1)
            cap[CHANNELS-1] = en_in && fall;
        // The last channel's capture closes the frame; its final bit is folded into the converted value.
        frame_done = cap[CHANNELS-1] && (bit_cnt == L'(DECIM - 1));
        for (int k = 0; k < CHANNELS; k++) begin
            tally_nxt[k]             = tally[k] + {{L{1'b0}}, cap[k] & mic_data_in};
            conv[k*OUT_W +: OUT_W]   = to_sample(tally_nxt[k]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt              <= '0;
            mic_clk_out      <= 1'b0;
            prev_clk         <= 1'b0;
            bit_cnt          <= '0;
            tally            <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            prev_clk <= mic_clk_out;
            if (!en_in) begin
                cnt         <= '0;
                mic_clk_out <= 1'b0;
                bit_cnt     <= '0;
                tally       <= '0;
            end else begin
                cnt         <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
                mic_clk_out <= (cnt < CW'(CLK_DIV / 2));
                if (cap[CHANNELS-1])
                    bit_cnt <= bit_cnt + 1'b1;
                tally <= frame_done ? '0 : tally_nxt;
            end

            if (frame_done) begin
                sample_out       <= conv;
                sample_valid_out <= 1'b1;
                if (sample_valid_out && !sample_ready_in)
                    overrun_out <= 1'b1;
            end else if (sample_valid_out && sample_ready_in) begin
                sample_valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Directed bench for pdm_mic_decimator: default, fast mono, stereo and short-frame instances.
// Expected samples are queued when a frame's stimulus is planned and popped on each accepted sample.
`timescale 1ns/1ps
module tb_pdm_mic_decimator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        en_a, data_a, mclk_a, tick_a, valid_a, ready_a, ovr_a;
    logic [7:0]  sample_a;
    logic        en_b, data_b, mclk_b, tick_b, valid_b, ready_b, ovr_b;
    logic [7:0]  sample_b;
    logic        en_c, data_c, mclk_c, tick_c, valid_c, ready_c, ovr_c;
    logic [15:0] sample_c;
    logic        en_d, data_d, mclk_d, tick_d, valid_d, ready_d, ovr_d;
    logic [7:0]  sample_d;

    // Stereo stimulus: the pin follows the mic clock, so rise captures see 1 and fall captures see 0.
    assign data_c = mclk_c;

    pdm_mic_decimator u_a (
        .clk_in(clk), .rst_in(rst), .en_in(en_a), .mic_data_in(data_a),
        .mic_clk_out(mclk_a), .pdm_tick_out(tick_a), .sample_out(sample_a),
        .sample_valid_out(valid_a), .sample_ready_in(ready_a), .overrun_out(ovr_a)
    );
    pdm_mic_decimator #(.CLK_DIV(4)) u_b (
        .clk_in(clk), .rst_in(rst), .en_in(en_b), .mic_data_in(data_b),
        .mic_clk_out(mclk_b), .pdm_tick_out(tick_b), .sample_out(sample_b),
        .sample_valid_out(valid_b), .sample_ready_in(ready_b), .overrun_out(ovr_b)
    );
    pdm_mic_decimator #(.CLK_DIV(4), .CHANNELS(2)) u_c (
        .clk_in(clk), .rst_in(rst), .en_in(en_c), .mic_data_in(data_c),
        .mic_clk_out(mclk_c), .pdm_tick_out(tick_c), .sample_out(sample_c),
        .sample_valid_out(valid_c), .sample_ready_in(ready_c), .overrun_out(ovr_c)
    );
    pdm_mic_decimator #(.CLK_DIV(4), .DECIM(16)) u_d (
        .clk_in(clk), .rst_in(rst), .en_in(en_d), .mic_data_in(data_d),
        .mic_clk_out(mclk_d), .pdm_tick_out(tick_d), .sample_out(sample_d),
        .sample_valid_out(valid_d), .sample_ready_in(ready_d), .overrun_out(ovr_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // 0: zeros, 1: ones, 2: alternating starting with 1, 3: three ones in every four bits.
    function automatic logic pat(input int mode, input int i);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (i % 2) == 0;
            default: return (i % 4) != 0;
        endcase
    endfunction

    int mq_b[$];
    int mq_d[$];
    logic [15:0] eq_b[$];
    logic [15:0] eq_c[$];
    logic [15:0] eq_d[$];
    int mode_b = 0, idx_b = 0, frames_b = 0, pops_b = 0;
    int mode_d = 0, idx_d = 0, pops_c = 0, pops_d = 0;

    // Data drivers: set the next bit mid-way through each rise cycle, ahead of the capturing edge.
    initial forever begin
        @(negedge clk);
        if (tick_b) begin
            if (idx_b == 0 && mq_b.size() > 0) mode_b = mq_b.pop_front();
            data_b = pat(mode_b, idx_b);
            idx_b++;
            if (idx_b == 256) begin
                idx_b = 0;
                frames_b++;
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (tick_d) begin
            if (idx_d == 0 && mq_d.size() > 0) mode_d = mq_d.pop_front();
            data_d = pat(mode_d, idx_d);
            idx_d = (idx_d + 1) % 16;
        end
    end

    // Scoreboard monitors: every accepted sample must match the oldest queued expectation.
    initial forever begin
        logic [15:0] e;
        @(negedge clk);
        #2;
        if (valid_b && ready_b) begin
            e = (eq_b.size() > 0) ? eq_b.pop_front() : 16'hxxxx;
            pops_b++;
            chk("b_sample", {8'h00, sample_b}, e);
        end
    end
    initial forever begin
        logic [15:0] e;
        @(negedge clk);
        #2;
        if (valid_c && ready_c) begin
            e = (eq_c.size() > 0) ? eq_c.pop_front() : 16'hxxxx;
            pops_c++;
            chk("c_sample", sample_c, e);
        end
    end
    initial forever begin
        logic [15:0] e;
        @(negedge clk);
        #2;
        if (valid_d && ready_d) begin
            e = (eq_d.size() > 0) ? eq_d.pop_front() : 16'hxxxx;
            pops_d++;
            chk("d_sample", {8'h00, sample_d}, e);
        end
    end

    initial begin
        int cyc, nt, t1, t2, highs, dbl, tcyc, vcyc, nf;
        logic prev_t, pm;
        logic [7:0] va;

        rst = 1'b1;
        en_a = 0; en_b = 0; en_c = 0; en_d = 0;
        ready_a = 0; ready_b = 0; ready_c = 0; ready_d = 0;
        data_a = 1'b1; data_b = 1'b0; data_d = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_mclk_a", mclk_a, 0);
        chk("rst_tick_a", tick_a, 0);
        chk("rst_sample_a", sample_a, 0);
        chk("rst_valid_b", valid_b, 0);
        chk("rst_ovr_b", ovr_b, 0);

        // Default instance: clock shape, tick width, first-sample latency, all-ones value.
        ready_a = 1'b1;
        en_a = 1'b1;
        cyc = 0; nt = 0; t1 = -1000; t2 = 0; highs = 0; dbl = 0; tcyc = -1000; vcyc = -1;
        prev_t = 1'b0; va = 8'h00;
        while (vcyc < 0 && cyc < 9000) begin
            step(1);
            cyc++;
            if (tick_a) begin
                nt++;
                if (nt == 1) t1 = cyc;
                if (nt == 2) t2 = cyc;
                if (nt == 256) tcyc = cyc;
                if (prev_t) dbl++;
            end
            if (nt == 1 && mclk_a) highs++;
            prev_t = tick_a;
            if (valid_a) begin
                vcyc = cyc;
                va = sample_a;
            end
        end
        chk("a_period", t2 - t1, 32);
        chk("a_high_cycles", highs, 16);
        chk("a_tick_width", dbl, 0);
        chk("a_ticks_at_valid", nt, 256);
        chk("a_valid_latency", vcyc, tcyc + 1);
        chk("a_sample_ones", va, 8'h7F);
        en_a = 1'b0;

        // Stereo: ch0 all ones, ch1 all zeros, sample 1 clk after the 256th falling edge.
        eq_c.push_back(16'h807F);
        ready_c = 1'b1;
        en_c = 1'b1;
        cyc = 0; nf = 0; tcyc = -1000; vcyc = -1; pm = 1'b0;
        while (vcyc < 0 && cyc < 1200) begin
            step(1);
            cyc++;
            if (!mclk_c && pm) begin
                nf++;
                if (nf == 256) tcyc = cyc;
            end
            pm = mclk_c;
            if (valid_c) vcyc = cyc;
        end
        chk("c_valid_latency", vcyc, tcyc + 1);
        step(2);
        en_c = 1'b0;
        chk("c_pops", pops_c, 1);

        // DECIM=16, OUT_W=8: left-shift scaling with clamp.
        mq_d.push_back(1); mq_d.push_back(0); mq_d.push_back(3);
        eq_d.push_back(16'h007F); eq_d.push_back(16'h0080); eq_d.push_back(16'h0040);
        ready_d = 1'b1;
        en_d = 1'b1;
        cyc = 0;
        while (pops_d < 3 && cyc < 400) begin step(1); cyc++; end
        en_d = 1'b0;
        chk("d_pops", pops_d, 3);

        // Fast mono: pattern values with ready held high.
        mq_b.push_back(1); mq_b.push_back(0); mq_b.push_back(2); mq_b.push_back(3);
        mq_b.push_back(3); mq_b.push_back(0); mq_b.push_back(1);
        eq_b.push_back(16'h007F); eq_b.push_back(16'h0080);
        eq_b.push_back(16'h0000); eq_b.push_back(16'h0040);
        ready_b = 1'b1;
        en_b = 1'b1;
        cyc = 0;
        while (pops_b < 4 && cyc < 4300) begin step(1); cyc++; end
        ready_b = 1'b0;
        chk("b_pattern_pops", pops_b, 4);

        // Frame 5 (64) is held; ready lands in the cycle frame 6 loads.
        cyc = 0;
        while (frames_b < 6 && cyc < 2200) begin step(1); cyc++; end
        chk("b_frames_6", frames_b, 6);
        eq_b.push_back(16'h0040);
        ready_b = 1'b1;
        step(1);
        ready_b = 1'b0;
        chk("b_coincide_valid", valid_b, 1);
        chk("b_coincide_sample", sample_b, 8'h80);
        chk("b_coincide_ovr", ovr_b, 0);
        chk("b_coincide_pops", pops_b, 5);

        // Frame 7 overwrites the unconsumed frame-6 sample.
        cyc = 0;
        while (frames_b < 7 && cyc < 1200) begin step(1); cyc++; end
        step(1);
        chk("b_overrun", ovr_b, 1);
        chk("b_overrun_valid", valid_b, 1);
        chk("b_overrun_sample", sample_b, 8'h7F);
        eq_b.push_back(16'h007F);
        ready_b = 1'b1;
        step(1);
        ready_b = 1'b0;
        chk("b_ready_drops_valid", valid_b, 0);
        chk("b_overrun_sticky", ovr_b, 1);
        chk("b_overrun_pops", pops_b, 6);

        // Abort a frame after 100 bits; the next sample must come from 256 fresh bits.
        cyc = 0;
        while (idx_b < 100 && cyc < 1200) begin step(1); cyc++; end
        en_b = 1'b0;
        step(10);
        idx_b = 0;
        mode_b = 3;
        eq_b.push_back(16'h0040);
        ready_b = 1'b1;
        en_b = 1'b1;
        cyc = 0;
        while (pops_b < 7 && cyc < 1200) begin step(1); cyc++; end
        ready_b = 1'b0;
        chk("b_reenable_pops", pops_b, 7);

        // Reset mid-frame with a held sample and overrun set.
        cyc = 0;
        while (frames_b < 9 && cyc < 1200) begin step(1); cyc++; end
        step(1);
        chk("b_pre_rst_valid", valid_b, 1);
        chk("b_pre_rst_ovr", ovr_b, 1);
        step(40);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        en_b = 1'b0;
        chk("b_rst_mclk", mclk_b, 0);
        chk("b_rst_tick", tick_b, 0);
        chk("b_rst_sample", sample_b, 0);
        chk("b_rst_valid", valid_b, 0);
        chk("b_rst_ovr", ovr_b, 0);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
